if_fetch_queue: RTL and testbench

- Parametrised successor to the single-entry fetch stage; sits between the next-PC logic and ID.
- Drives a SRAM-like request/response instruction port (req/addr_ok/data_ok) with up to MAX_OUTSTANDING requests in flight.
- Buffers returned instructions in an IBUF_DEPTH-entry FIFO so fetch is decoupled from ID stalls.
- Handles branch and flush redirects, discarding stale responses, and flags misaligned PCs (ADEF) instead of fetching them.

---
 rtl/if_fetch_queue.sv | 122 ++++++++++++
 tb/tb_if_fetch_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage with multiple outstanding SRAM-like requests and an
// instruction buffer that decouples fetch from ID stalls.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          IBUF_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_allowin,
  input  logic [32:0] br_bus,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic        if_id_valid,
  output logic [64:0] if_id_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);
  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = $clog2(IBUF_DEPTH + 1);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [31:0]   fetch_pc;
  logic [64:0]   ibuf [IBUF_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count, inflight, discard;
  logic [31:0]   pcq [MAX_OUTSTANDING];
  logic [QW-1:0] qwp, qrp;
  logic          adef_stall;

  logic          br_taken, redirect, pc_aligned, hs, drop, resp_push, adef_push, push, pop;
  logic [31:0]   target;
  logic [CW:0]   credit_sum;
  logic [CW-1:0] inflight_nxt;
  logic [64:0]   push_data;

  function automatic logic [QW-1:0] qinc(input logic [QW-1:0] q);
    return (q == QW'(MAX_OUTSTANDING - 1)) ? '0 : q + 1'b1;
  endfunction

  assign br_taken   = br_bus[32];
  assign redirect   = flush | br_taken;
  assign target     = flush ? flush_target : br_bus[31:0];
  assign pc_aligned = (fetch_pc[1:0] == 2'b00);
  assign credit_sum = {1'b0, inflight} + {1'b0, count};

  // Credit covers both in-flight requests and buffered entries, so a response
  // always finds room in the buffer.
  assign inst_sram_req = resetn & ~redirect & ~adef_stall & pc_aligned
                       & (inflight < CW'(MAX_OUTSTANDING))
                       & (credit_sum < (CW+1)'(IBUF_DEPTH));
  assign inst_sram_addr  = fetch_pc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;

  assign hs        = inst_sram_req & inst_sram_addr_ok;
  assign drop      = inst_sram_data_ok & (discard != '0);
  assign resp_push = inst_sram_data_ok & ~drop & ~redirect;
  assign adef_push = ~pc_aligned & ~adef_stall & (inflight == '0)
                   & (count != CW'(IBUF_DEPTH)) & ~redirect;
  assign push      = resp_push | adef_push;
  assign push_data = adef_push ? {1'b1, fetch_pc, 32'h0}
                               : {1'b0, pcq[qrp], inst_sram_rdata};

  assign if_id_valid = resetn & (count != '0) & ~redirect;
  assign if_id_bus   = ibuf[rptr];
  assign pop         = if_id_valid & id_allowin;

  assign inflight_nxt = inflight + CW'(hs) - CW'(inst_sram_data_ok);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc   <= RESET_PC;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      inflight   <= '0;
      discard    <= '0;
      qwp        <= '0;
      qrp        <= '0;
      adef_stall <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect) begin
        // inflight already includes responses still owed to earlier redirects
        fetch_pc   <= target;
        wptr       <= '0;
        rptr       <= '0;
        count      <= '0;
        qwp        <= '0;
        qrp        <= '0;
        adef_stall <= 1'b0;
        discard    <= inflight_nxt;
      end else begin
        discard <= discard - CW'(drop);
        if (hs) begin
          fetch_pc <= fetch_pc + 32'd4;
          qwp      <= qinc(qwp);
        end
        if (resp_push) qrp <= qinc(qrp);
        if (adef_push) adef_stall <= 1'b1;
        if (push) wptr <= wptr + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && !redirect && hs) pcq[qwp] <= fetch_pc;
    if (resetn && push) ibuf[wptr] <= push_data;
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: memory model with configurable
// latency/acceptance, monitor comparing every instruction delivered to ID.
module tb_if_fetch_queue;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        resetn, id_allowin, flush;
  logic [32:0] br_bus;
  logic [31:0] flush_target;
  logic        if_id_valid;
  logic [64:0] if_id_bus;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic        inst_sram_addr_ok = 1'b0, inst_sram_data_ok = 1'b0;

  if_fetch_queue dut (
    .clk(clk), .resetn(resetn), .id_allowin(id_allowin), .br_bus(br_bus),
    .flush(flush), .flush_target(flush_target), .if_id_valid(if_id_valid),
    .if_id_bus(if_id_bus), .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; int age; } ment_t;
  ment_t       mq[$];
  logic [64:0] sbq[$];
  int          cmp_cnt = 0, err_cnt = 0, hs_cnt = 0, dlv_cnt = 0;
  int          lat = 0;
  logic        aok_en = 1'b1, expect_idle = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0, last_pc = 32'h0;

  function automatic logic [31:0] ifn(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [64:0] got, input logic [64:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  // Memory drives at negedge; everything is sampled 1 time unit before posedge.
  always @(negedge clk) begin
    inst_sram_addr_ok = aok_en;
    inst_sram_data_ok = resetn && (mq.size() > 0) && (mq[0].age >= lat);
    inst_sram_rdata   = inst_sram_data_ok ? ifn(mq[0].a) : 32'h0;
    #4;
    if (!resetn) begin
      mq.delete();
      pend = 1'b0;
    end else begin
      if (pend && !flush && !br_bus[32])
        chk("addr_stable", {inst_sram_req, inst_sram_addr}, {1'b1, pend_addr});
      pend      = inst_sram_req && !inst_sram_addr_ok;
      pend_addr = inst_sram_addr;
      if (expect_idle) chk("stall_idle", if_id_valid, 1'b0);
      else if (if_id_valid && id_allowin) begin
        logic [64:0] e;
        logic [31:0] np;
        if (sbq.size() > 0) e = sbq.pop_front();
        else begin
          np = last_pc + 32'd4;
          e  = {1'b0, np, ifn(np)};
        end
        chk("deliver", if_id_bus, e);
        last_pc = if_id_bus[63:32];
        dlv_cnt++;
      end
      if (inst_sram_data_ok) void'(mq.pop_front());
      foreach (mq[i]) mq[i].age++;
      if (inst_sram_req && inst_sram_addr_ok) begin
        mq.push_back('{a: inst_sram_addr, age: 0});
        hs_cnt++;
      end
      chk("mem_outstanding_le_max", (mq.size() <= MAXO), 1'b1);
      chk("inflight_le_max", (int'(dut.inflight) <= MAXO), 1'b1);
      chk("discard_le_max", (int'(dut.discard) <= MAXO), 1'b1);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_dlv(input int n, input int budget, input string nm);
    int start;
    logic ok;
    start = dlv_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      #2;
      if (dlv_cnt - start >= n) ok = 1'b1;
    end
    chk(nm, ok, 1'b1);
  endtask

  task automatic wait_sb(input int budget, input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      #2;
      if (sbq.size() == 0) ok = 1'b1;
    end
    chk(nm, ok, 1'b1);
  endtask

  initial begin
    logic found;
    logic [31:0] hold_addr;
    resetn = 1'b0; id_allowin = 1'b1; flush = 1'b0; br_bus = 33'h0; flush_target = 32'h0;
    repeat (3) step();
    #2;
    chk("rst_req", inst_sram_req, 1'b0);
    chk("rst_valid", if_id_valid, 1'b0);
    chk("const_size_wr", {inst_sram_size, inst_sram_wr, inst_sram_wstrb, inst_sram_wdata}, {2'b10, 37'h0});

    // 1: back-to-back sequential fetch
    step();
    sbq.push_back({1'b0, 32'h1c000000, ifn(32'h1c000000)});
    resetn = 1'b1;
    #2;
    chk("t1_first_req", {inst_sram_req, inst_sram_addr}, {1'b1, 32'h1c000000});
    step();
    #2;
    chk("t1_second_req", {inst_sram_req, inst_sram_addr}, {1'b1, 32'h1c000004});
    wait_dlv(8, 40, "t1_stream");

    // 2: ID stalled, buffer fills, nothing lost
    step();
    id_allowin = 1'b0;
    repeat (20) step();
    #2;
    chk("t2_req_stopped", inst_sram_req, 1'b0);
    chk("t2_credit_full", hs_cnt - dlv_cnt, 4);
    chk("t2_valid", if_id_valid, 1'b1);
    step();
    id_allowin = 1'b1;
    wait_dlv(8, 40, "t2_resume");

    // 3: branch with requests in flight and buffered entries
    step();
    id_allowin = 1'b0;
    lat = 2;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      #2;
      if (mq.size() == 2 && (hs_cnt - dlv_cnt - mq.size()) >= 1) found = 1'b1;
    end
    chk("t3_setup", found, 1'b1);
    br_bus = {1'b1, 32'h1c000100};
    sbq.push_back({1'b0, 32'h1c000100, ifn(32'h1c000100)});
    #1;
    chk("t3_valid_blocked", if_id_valid, 1'b0);
    chk("t3_req_blocked", inst_sram_req, 1'b0);
    step();
    br_bus = 33'h0;
    id_allowin = 1'b1;
    lat = 0;
    wait_sb(40, "t3_target_delivered");
    wait_dlv(4, 40, "t3_after");

    // 4: flush beats branch in the same cycle
    step();
    flush = 1'b1; flush_target = 32'h1c008000; br_bus = {1'b1, 32'h1c000200};
    sbq.push_back({1'b0, 32'h1c008000, ifn(32'h1c008000)});
    #1;
    chk("t4_valid_blocked", if_id_valid, 1'b0);
    step();
    flush = 1'b0; br_bus = 33'h0;
    #2;
    chk("t4_fetch_addr", inst_sram_addr, 32'h1c008000);
    wait_sb(40, "t4_target_delivered");
    wait_dlv(4, 40, "t4_after");

    // 5: misaligned target raises ADEF and stalls until redirected
    step();
    br_bus = {1'b1, 32'h1c000102};
    sbq.push_back({1'b1, 32'h1c000102, 32'h0});
    step();
    br_bus = 33'h0;
    wait_sb(40, "t5_adef_delivered");
    step();
    expect_idle = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      #2;
      chk("t5_no_req", inst_sram_req, 1'b0);
    end
    step();
    expect_idle = 1'b0;
    flush = 1'b1; flush_target = 32'h1c000000;
    sbq.push_back({1'b0, 32'h1c000000, ifn(32'h1c000000)});
    step();
    flush = 1'b0;
    wait_sb(40, "t5_recover");
    wait_dlv(4, 40, "t5_after");

    // 6: addr_ok withheld, then streaming with coincident handshake/response
    step();
    aok_en = 1'b0;
    #2;
    hold_addr = inst_sram_addr;
    for (int i = 0; i < 5; i++) begin
      step();
      #2;
      chk("t6_req_held", {inst_sram_req, inst_sram_addr}, {1'b1, hold_addr});
    end
    step();
    aok_en = 1'b1;
    wait_dlv(12, 60, "t6_stream");
    chk("t6_sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
